// File: rtl/tdes_key_pkg.sv
// Shared constants for the Triple-DES round-key sequencer: FSM states, DES shift schedule, PC-1 and helpers.
// No logic or latency of its own; backpressure is not applicable.
package tdes_key_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam logic [1:0] STAGE_0 = 2'd0;
    localparam logic [1:0] STAGE_1 = 2'd1;
    localparam logic [1:0] STAGE_2 = 2'd2;

    // Entry r-1 is the left-rotation applied to reach round r.
    localparam logic [1:0] SHIFT_SCHED [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Key bit positions numbered 1..64 from the MSB; first 28 entries form C, the rest D.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[55-i] = key[64-PC1_TBL[i]];
        end
        return cd;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] n);
        return (n == 2'd2) ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    function automatic logic [55:0] rotl_cd(input logic [55:0] cd, input logic [1:0] n);
        return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
    endfunction

    function automatic logic [55:0] rotr_cd(input logic [55:0] cd, input logic [1:0] n);
        return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    endfunction

endpackage

// File: rtl/key_56_to_48.sv
// DES PC-2: selects 48 of the 56 {C,D} bits to form a round key.
// Purely combinational, zero latency; no backpressure.
module key_56_to_48 (
    input  logic [55:0] cd_i,
    output logic [47:0] key_o
);

    // Positions numbered 1..56 from the MSB of {C,D}.
    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    always_comb begin
        key_o = '0;
        for (int j = 0; j < 48; j++) begin
            key_o[47-j] = cd_i[56-PC2_TBL[j]];
        end
    end

endmodule

// File: rtl/tdes_key_sequencer.sv
// Triple-DES round-key scheduler: emits 48 keys (EDE or DED order) from one C/D register pair.
// First key two cycles after start, then one per accept plus one LOAD bubble per stage; key held while rk_ready_i is low.
module tdes_key_sequencer
    import tdes_key_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        decrypt_i,
    input  logic        abort_i,
    input  logic [63:0] key1_64_i,
    input  logic [63:0] key2_64_i,
    input  logic [63:0] key3_64_i,
    output logic        busy_o,
    output logic        rk_valid_o,
    input  logic        rk_ready_i,
    output logic [47:0] round_key_o,
    output logic [3:0]  round_idx_o,
    output logic [1:0]  stage_o,
    output logic        stage_dec_o,
    output logic        done_o
);

    logic [1:0]  state_q, state_d;
    logic        dec_q, dec_d;
    logic [63:0] key1_q, key1_d;
    logic [63:0] key2_q, key2_d;
    logic [63:0] key3_q, key3_d;
    logic [1:0]  stage_q, stage_d;
    logic [55:0] cd_q, cd_d;
    logic [3:0]  idx_q, idx_d;

    logic        stage_dec;
    logic        last_key;
    logic [63:0] sel_key;

    // Middle stage runs the opposite DES direction from the outer two.
    assign stage_dec = (state_q != ST_IDLE) &&
                       ((stage_q == STAGE_1) ? (dec_q == MODE_ENC) : (dec_q == MODE_DEC));
    assign last_key  = stage_dec ? (idx_q == 4'd1) : (idx_q == 4'd16);

    always_comb begin
        sel_key = key2_q;
        case (stage_q)
            STAGE_0: sel_key = dec_q ? key3_q : key1_q;
            STAGE_1: sel_key = key2_q;
            STAGE_2: sel_key = dec_q ? key1_q : key3_q;
            default: sel_key = key2_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        key1_d  = key1_q;
        key2_d  = key2_q;
        key3_d  = key3_q;
        stage_d = stage_q;
        cd_d    = cd_q;
        idx_d   = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    dec_d   = decrypt_i;
                    key1_d  = key1_64_i;
                    key2_d  = key2_64_i;
                    key3_d  = key3_64_i;
                    stage_d = STAGE_0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Reverse stages start at C16/D16, which equals C0/D0 after the full 28-bit rotation.
                if (stage_dec) begin
                    cd_d  = pc1(sel_key);
                    idx_d = 4'd16;
                end else begin
                    cd_d  = rotl_cd(pc1(sel_key), 2'd1);
                    idx_d = 4'd1;
                end
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (rk_ready_i) begin
                    if (last_key) begin
                        if (stage_q != STAGE_2) begin
                            stage_d = stage_q + 2'd1;
                            state_d = ST_LOAD;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (stage_dec) begin
                        cd_d  = rotr_cd(cd_q, SHIFT_SCHED[idx_q - 4'd1]);
                        idx_d = idx_q - 4'd1;
                    end else begin
                        cd_d  = rotl_cd(cd_q, SHIFT_SCHED[idx_q]);
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                stage_d = STAGE_0;
                cd_d    = '0;
                idx_d   = 4'd0;
            end
        endcase

        if (abort_i) begin
            state_d = ST_IDLE;
            stage_d = STAGE_0;
            cd_d    = '0;
            idx_d   = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dec_q   <= 1'b0;
            key1_q  <= '0;
            key2_q  <= '0;
            key3_q  <= '0;
            stage_q <= STAGE_0;
            cd_q    <= '0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            key1_q  <= key1_d;
            key2_q  <= key2_d;
            key3_q  <= key3_d;
            stage_q <= stage_d;
            cd_q    <= cd_d;
            idx_q   <= idx_d;
        end
    end

    key_56_to_48 u_pc2 (
        .cd_i  (cd_q),
        .key_o (round_key_o)
    );

    assign busy_o      = (state_q != ST_IDLE);
    assign rk_valid_o  = (state_q == ST_EMIT);
    assign done_o      = (state_q == ST_DONE);
    assign round_idx_o = idx_q;
    assign stage_o     = stage_q;
    assign stage_dec_o = stage_dec;

endmodule

// File: tb/tb_tdes_key_sequencer.sv
// Bench for tdes_key_sequencer: directed steps with random keys/backpressure against a
// textbook DES key-schedule model (cumulative rotation per round).
module tb_tdes_key_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        decrypt_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [63:0] key1_64_i = '0;
    logic [63:0] key2_64_i = '0;
    logic [63:0] key3_64_i = '0;
    logic        busy_o;
    logic        rk_valid_o;
    logic        rk_ready_i = 1'b0;
    logic [47:0] round_key_o;
    logic [3:0]  round_idx_o;
    logic [1:0]  stage_o;
    logic        stage_dec_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    logic [47:0] got_key [48];
    logic        got_sd  [48];
    int          final_edge;

    localparam logic [63:0] KTEST = 64'h133457799BBCDFF1;
    localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    tdes_key_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .decrypt_i   (decrypt_i),
        .abort_i     (abort_i),
        .key1_64_i   (key1_64_i),
        .key2_64_i   (key2_64_i),
        .key3_64_i   (key3_64_i),
        .busy_o      (busy_o),
        .rk_valid_o  (rk_valid_o),
        .rk_ready_i  (rk_ready_i),
        .round_key_o (round_key_o),
        .round_idx_o (round_idx_o),
        .stage_o     (stage_o),
        .stage_dec_o (stage_dec_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    // Round key r of a DES key: PC-1, rotate C and D by the cumulative shift up to r, then PC-2.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int r);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] sk;
        int tot;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1[i]];
            d[27-i] = k[64-PC1[28+i]];
        end
        tot = 0;
        for (int i = 0; i < r; i++) tot += SH[i];
        for (int i = 0; i < tot; i++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int j = 0; j < 48; j++) sk[47-j] = cd[56-PC2[j]];
        return sk;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input logic [63:0] k1, input logic [63:0] k2, input logic [63:0] k3,
                           input logic dec, input bit rnd, input bit noise);
        logic [54:0] exp_q [$];
        logic [54:0] obs, held;
        logic [63:0] sk;
        logic        sd;
        bit          stalled;
        int          n, acc, r;
        for (int s = 0; s < 3; s++) begin
            sk = dec ? (s == 0 ? k3 : (s == 1 ? k2 : k1)) : (s == 0 ? k1 : (s == 1 ? k2 : k3));
            sd = dec ^ (s == 1);
            for (int i = 0; i < 16; i++) begin
                r = sd ? 16 - i : i + 1;
                exp_q.push_back({s[1:0], sd, r[3:0], ref_subkey(sk, r)});
            end
        end
        key1_64_i = k1; key2_64_i = k2; key3_64_i = k3; decrypt_i = dec;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("load_cycle", {62'd0, busy_o, rk_valid_o}, 64'd2);
        n = 0; acc = 0; stalled = 0; held = '0;
        while (acc < 48 && n < 2000) begin
            tick();
            n++;
            obs = {stage_o, stage_dec_o, round_idx_o, round_key_o};
            if (stalled) chk("hold", {8'd0, rk_valid_o, obs}, {8'd0, 1'b1, held});
            if (noise) begin
                start_i   = 1'($urandom_range(0, 1));
                decrypt_i = 1'($urandom_range(0, 1));
                key1_64_i = {$urandom, $urandom};
                key3_64_i = {$urandom, $urandom};
            end
            rk_ready_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rk_valid_o && rk_ready_i) begin
                chk($sformatf("key%0d", acc), {9'd0, obs}, {9'd0, exp_q.pop_front()});
                got_key[acc] = round_key_o;
                got_sd[acc]  = stage_dec_o;
                acc++;
                stalled = 0;
            end else begin
                stalled = rk_valid_o;
                held    = obs;
            end
        end
        final_edge = n + 1;
        if (acc < 48) chk("timeout_accepts", 64'(acc), 64'd48);
        tick();
        start_i = 1'b0;
        rk_ready_i = 1'b0;
        chk("done_pulse", {61'd0, done_o, busy_o, rk_valid_o}, 64'd6);
        tick();
        chk("back_idle", {55'd0, done_o, busy_o, round_idx_o, stage_o}, 64'd0);
    endtask

    initial begin
        logic [63:0] ka, kb, kc;
        bit seen;
        int n;

        #12;
        chk("reset_outputs", {busy_o, rk_valid_o, round_key_o, round_idx_o, stage_o, stage_dec_o, done_o},
            64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", {62'd0, busy_o, done_o}, 64'd0);

        // Known-answer run, encrypt, ready held high.
        run_seq(KTEST, KTEST, KTEST, 1'b0, 1'b0, 1'b0);
        chk("enc_s0_r1",  {16'd0, got_key[0]},  64'h1B02EFFC7072);
        chk("enc_s0_r16", {16'd0, got_key[15]}, 64'hCB3D8B0E17F5);
        chk("enc_s1_first", {16'd0, got_key[16]}, 64'hCB3D8B0E17F5);
        chk("enc_final_edge", 64'(final_edge), 64'd51);

        // Known-answer run, decrypt.
        run_seq(KTEST, KTEST, KTEST, 1'b1, 1'b0, 1'b0);
        chk("dec_s0_first", {16'd0, got_key[0]},  64'hCB3D8B0E17F5);
        chk("dec_s0_last",  {16'd0, got_key[15]}, 64'h1B02EFFC7072);
        chk("dec_stage_dec", {61'd0, got_sd[0], got_sd[16], got_sd[32]}, 64'd5);

        // Distinct random keys in both modes; decrypt must start from key3 round 16.
        ka = {$urandom, $urandom}; kb = {$urandom, $urandom}; kc = {$urandom, $urandom};
        run_seq(ka, kb, kc, 1'b0, 1'b0, 1'b0);
        run_seq(ka, kb, kc, 1'b1, 1'b0, 1'b0);
        chk("dec_key3_first", {16'd0, got_key[0]}, {16'd0, ref_subkey(kc, 16)});

        // Random backpressure, with start/mode/key inputs churning while busy.
        for (int t = 0; t < 2; t++) begin
            ka = {$urandom, $urandom}; kb = {$urandom, $urandom}; kc = {$urandom, $urandom};
            run_seq(ka, kb, kc, 1'(t), 1'b1, 1'b1);
        end

        // abort together with start in IDLE: stays idle.
        start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        chk("abort_beats_start", {63'd0, busy_o}, 64'd0);

        // abort mid-stage1.
        key1_64_i = ka; key2_64_i = kb; key3_64_i = kc; decrypt_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        rk_ready_i = 1'b1;
        n = 0;
        while (!(stage_o == 2'd1 && round_idx_o == 4'd5 && rk_valid_o) && n < 200) begin
            tick();
            n++;
        end
        chk("reach_s1_r5", {62'd0, stage_o}, 64'd1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abort_drops", {62'd0, rk_valid_o, busy_o}, 64'd0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen |= done_o | rk_valid_o | busy_o;
        end
        chk("abort_no_done", {63'd0, seen}, 64'd0);
        rk_ready_i = 1'b0;
        run_seq(kc, ka, kb, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset at stage 2 round 7.
        key1_64_i = ka; key2_64_i = kb; key3_64_i = kc; decrypt_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        rk_ready_i = 1'b1;
        n = 0;
        while (!(stage_o == 2'd2 && round_idx_o == 4'd7) && n < 200) begin
            tick();
            n++;
        end
        chk("reach_s2_r7", {60'd0, stage_o, round_idx_o[1:0]}, 64'd11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            {busy_o, rk_valid_o, round_key_o, round_idx_o, stage_o, stage_dec_o, done_o}, 64'd0);
        rk_ready_i = 1'b0;
        tick();
        #3 rst_n = 1'b1;
        tick();
        chk("idle_after_rst", {62'd0, busy_o, rk_valid_o}, 64'd0);
        run_seq(ka, kb, kc, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdes_key_sequencer.md
# tdes_key_sequencer

Sequential Triple-DES round-key scheduler. It latches three 64-bit keys and a mode, then emits the 48 round keys (3 stages × 16 rounds) one per accepted handshake, in the order the round datapath consumes them. Encrypt runs E(K1)-D(K2)-E(K3); decrypt runs D(K3)-E(K2)-D(K1). It sits between key registers and the iterative DES round engine, replacing a fully unrolled 16-key generator with one C/D register pair plus one PC-2 instance.

## Interface
- No parameters; the DES shift schedule and PC-1 are fixed constants.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a 48-key sequence; sampled only in IDLE
- decrypt  in  1  mode, latched with start: 0 = EDE encrypt, 1 = DED decrypt
- abort  in  1  synchronous; returns to IDLE from any state with no done pulse
- key1_64, key2_64, key3_64  in  [1:64] each  DES keys with parity bits, bit 1 = MSB; latched on start
- busy  out  1  high in any state other than IDLE
- rk_valid  out  1  round_key valid
- rk_ready  in  1  consumer accepts round_key when rk_valid && rk_ready
- round_key  out  [1:48]  PC-2 of the current {C,D}
- round_idx  out  4  DES round number of round_key, 1..16; 0 in IDLE
- stage  out  2  current stage 0..2; 0 in IDLE
- stage_dec  out  1  1 when the current stage applies DES decryption (reverse key order)
- done  out  1  one-cycle pulse after the 48th key is accepted

## Operation
- States: IDLE → LOAD → EMIT → (LOAD | DONE) → IDLE.
- IDLE: on start, latch keys and mode, stage←0, go to LOAD.
- Stage key selection: encrypt uses key1, key2, key3. Decrypt uses key3, key2, key1.
- stage_dec: encrypt 0,1,0. Decrypt 1,0,1.
- LOAD (1 cycle): {C,D} ← PC-1(selected key).
  - Forward stage (stage_dec = 0): rotate C and D left by 1, then round_idx←1.
  - Reverse stage (stage_dec = 1): no rotation (C16 = C0), then round_idx←16.
- Shift schedule, indexed by round 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- EMIT: rk_valid = 1. On accept:
  - Forward, round_idx < 16: rotate C and D left by shift[round_idx+1]; round_idx+1.
  - Reverse, round_idx > 1: rotate C and D right by shift[round_idx]; round_idx−1.
  - Accepting the last key of a stage (16 forward, 1 reverse): if stage < 2, stage+1 and go to LOAD; otherwise go to DONE.
- DONE (1 cycle): done = 1, then go to IDLE.
- round_key, round_idx and stage_dec are held stable while rk_valid && !rk_ready.
- start while busy is ignored. Key inputs are ignored after latching.
- If abort and start are high in the same IDLE cycle, abort wins and the sequencer stays IDLE.
- abort in EMIT drops rk_valid on the next cycle; no further keys are emitted.

## Timing
- Reset values: busy 0, rk_valid 0, round_key 0, round_idx 0, stage 0, stage_dec 0, done 0. The C/D and key registers clear to 0.
- Asynchronous reset mid-sequence: all outputs take their reset values immediately; the partial sequence is discarded.
- start sampled high at edge T: LOAD in T+1, first rk_valid in T+2.
- Each accept advances by exactly one key. With rk_ready held high, one key per cycle, plus one LOAD bubble per stage.
- Total with rk_ready held high: 51 cycles from the start edge to the final accept; done is high the cycle after the final accept; busy drops the cycle after done.
- round_key is combinational from the C/D registers through PC-2 only, with no registered stage: zero latency relative to round_idx.

## Structure
- Package tdes_key_pkg holds:
  - the state enum (IDLE, LOAD, EMIT, DONE);
  - the shift-schedule constant array;
  - the PC-1 index table;
  - the stage and mode encodings.
- Sub-module: instantiate the existing key_56_to_48 (PC-2) once on {C,D}.
- All rotation and sequencing logic stays in this module.

## Test plan
- All keys 0x133457799BBCDFF1, decrypt 0, rk_ready high:
  - stage0 round1 = 0x1B02EFFC7072, stage0 round16 = 0xCB3D8B0E17F5;
  - stage1 first key (round_idx 16) = 0xCB3D8B0E17F5;
  - done in the cycle after the 51st-cycle accept.
- Same keys, decrypt 1: stage0 emits round_idx 16..1, first key 0xCB3D8B0E17F5, last key 0x1B02EFFC7072; stage_dec sequence 1,0,1.
- Distinct keys in both modes: all 48 keys match a software key schedule; key3 is used first in decrypt.
- rk_ready toggled pseudo-randomly: round_key and round_idx are held across stall cycles; no key is skipped or duplicated.
- start pulsed while busy: ignored. abort mid-stage1: rk_valid drops, busy drops, no done; a new start then produces a clean sequence.
- rst_n asserted at round 7 of stage 2: outputs go to 0 immediately; after release the block is IDLE and accepts start.
